// File: rtl/if_id_fetch_stage_if.sv
// Fetch-stage bundle: hazard controls, redirect, instruction memory port and IF/ID outputs.
// Optional stall_count member is present only when FETCH_STALL_CNT_EN is defined.
// master = the fetch stage, slave = the surrounding pipeline/testbench.
interface if_id_fetch_stage_if;
   // hazard unit controls
   logic        PC_Stop;
   logic        stall;
   // redirect from decode
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   // instruction memory
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   // fetch PC and IF/ID register
   logic [31:0] pc;
   logic [31:0] instr_id;
   logic [31:0] pc_plus4_id;
   logic        valid_id;
`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_count;
`endif

   modport master (
      input  PC_Stop, stall, branch_taken, branch_target, jump, jump_target, imem_rdata,
      output imem_addr, pc, instr_id, pc_plus4_id, valid_id
`ifdef FETCH_STALL_CNT_EN
      , output stall_count
`endif
   );

   modport slave (
      output PC_Stop, stall, branch_taken, branch_target, jump, jump_target, imem_rdata,
      input  imem_addr, pc, instr_id, pc_plus4_id, valid_id
`ifdef FETCH_STALL_CNT_EN
      , input stall_count
`endif
   );
endinterface

// File: rtl/if_id_fetch_stage.sv
// Purpose: MIPS-32 fetch stage; owns the PC and the IF/ID register (optional stall counter: FETCH_STALL_CNT_EN).
// Latency: 1 cycle fetch-to-IF/ID; taken branch/jump costs one bubble cycle.
// Backpressure: PC_Stop freezes the PC, stall freezes IF/ID; a redirect seen while frozen is dropped.
module if_id_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   if_id_fetch_stage_if.master      fe
);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
      logic        valid;
   } if_id_t;

   logic [31:0] pc_q;
   logic [31:0] pc_plus4;
   logic [31:0] redirect_target;
   logic        redirect;
   if_id_t      if_id_q;

   // Branch wins over jump when decode raises both.
   assign redirect        = fe.branch_taken | fe.jump;
   assign redirect_target = fe.branch_taken ? fe.branch_target : fe.jump_target;
   assign pc_plus4        = pc_q + 32'd4;   // wraps modulo 2^32

   // Program counter: hold on PC_Stop, else redirect or sequential.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc_q <= RESET_PC;
      else if (!fe.PC_Stop)
         pc_q <= redirect ? redirect_target : pc_plus4;
   end

   // IF/ID register: hold on stall, squash to a bubble on redirect, else capture the fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         if_id_q <= '0;
      else if (!fe.stall) begin
         if (redirect)
            if_id_q <= '0;
         else
            if_id_q <= '{instr: fe.imem_rdata, pc_plus4: pc_plus4, valid: 1'b1};
      end
   end

   assign fe.imem_addr   = pc_q;
   assign fe.pc          = pc_q;
   assign fe.instr_id    = if_id_q.instr;
   assign fe.pc_plus4_id = if_id_q.pc_plus4;
   assign fe.valid_id    = if_id_q.valid;

`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   // Count stalled edges, saturating rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt_q <= '0;
      else if (fe.stall && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign fe.stall_count = stall_cnt_q;
`endif

endmodule

// File: doc/if_id_fetch_stage.md
# if_id_fetch_stage

Instruction-fetch stage of the 5-stage MIPS-32 pipeline: owns the program counter, drives the instruction-memory address, and registers the fetched instruction into the IF/ID pipeline register. It sits directly upstream of decode and the hazard detection unit. It honours that unit's `PC_Stop` and `stall` outputs to freeze the front end on load-use hazards, and squashes the IF/ID slot on taken branches and jumps.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `PC_Stop`  in  1  hold PC (from hazard unit).
- `stall`  in  1  hold IF/ID register (from hazard unit).
- `branch_taken`  in  1  branch resolved taken in ID.
- `branch_target`  in  32  branch destination.
- `jump`  in  1  J/JAL decoded in ID.
- `jump_target`  in  32  jump destination, already formed as {PC+4[31:28], imm26, 2'b00}.
- `imem_addr`  out  32  instruction memory address; combinational copy of `pc`.
- `imem_rdata`  in  32  instruction word; combinational read, valid in the same cycle as `imem_addr`.
- `pc`  out  32  current fetch PC (registered).
- `instr_id`  out  32  IF/ID instruction.
- `pc_plus4_id`  out  32  IF/ID PC+4.
- `valid_id`  out  1  IF/ID holds a real instruction.
- `stall_count`  out  32  present only with `FETCH_STALL_CNT_EN`.

## Operation
- `redirect = branch_taken | jump`. Target selection: `branch_target` if `branch_taken`, else `jump_target`. Branch has priority when both are asserted.
- PC next-state, in priority order:
  1. `rst`
  2. `PC_Stop` = hold
  3. `redirect` = target
  4. else `pc + 4`
- PC arithmetic is 32-bit unsigned, wrapping modulo 2^32 (32'hFFFF_FFFC + 4 = 0). Bits [1:0] are carried as given; no alignment check.
- IF/ID next-state, in priority order:
  1. `rst` = all zero
  2. `stall` = hold all fields
  3. `redirect` = bubble (`instr_id` = 0, i.e. sll $0,$0,0; `pc_plus4_id` = 0; `valid_id` = 0)
  4. else load `imem_rdata`, `pc + 4`, and 1
- Redirect while `stall`/`PC_Stop` is high is dropped, not queued. Decode re-presents the redirect once the stall clears, because the branch is itself the stalled instruction.
- `PC_Stop` and `stall` are expected to be equal. If they differ, each register obeys only its own control; no cross-checking.

## Timing
- Reset values:
  - `pc` = `RESET_PC`; `imem_addr` = `RESET_PC`.
  - `instr_id` = 0, `pc_plus4_id` = 0, `valid_id` = 0.
  - `stall_count` = 0.
- Reset asserted mid-operation clears all state immediately, independent of `clk`.
- First fetch after reset deassertion: the `imem_rdata` at `RESET_PC` is captured on the first rising edge. `valid_id` = 1 after that edge.
- Fetch-to-IF/ID latency: 1 cycle. An instruction addressed in cycle N is in `instr_id` in cycle N+1.
- Redirect asserted in cycle N (no stall):
  - `pc` = target in cycle N+1.
  - IF/ID holds a bubble in cycle N+1; the wrong-path instruction is discarded.
  - Target instruction reaches `instr_id` in cycle N+2. Branch penalty is 1 cycle.
- Stall held for K cycles:
  - `pc` and IF/ID are frozen for K cycles.
  - Fetch resumes on the first edge with `stall` = 0.
- All outputs are registered except `imem_addr`.

## Configuration
- `FETCH_STALL_CNT_EN` defined:
  - 32-bit `stall_count` port and register are present.
  - The counter increments on every rising edge with `stall` = 1 and saturates at 32'hFFFF_FFFF (no wrap).
  - It clears only on `rst`.
- `FETCH_STALL_CNT_EN` undefined: the port and the register are absent. All other behaviour is identical.

## Test plan
- Reset release, `RESET_PC` = 0, `imem` returns 0x2008_0005 at address 0 -> after edge 1: `pc` = 4, `instr_id` = 0x2008_0005, `pc_plus4_id` = 4, `valid_id` = 1.
- Straight-line fetch, 4 edges -> `pc` sequence 4, 8, 12, 16, with `instr_id` tracking mem[0..3] one cycle behind.
- `stall` = `PC_Stop` = 1 for 2 cycles at `pc` = 8 -> `pc` stays 8 and `instr_id` is unchanged for 2 cycles; on release `pc` = 12 and the mem[8] instruction is loaded.
- `branch_taken` = 1 with `branch_target` = 0x40 at `pc` = 12 -> next cycle `pc` = 0x40 with `valid_id` = 0 and `instr_id` = 0; following cycle `instr_id` = mem[0x40] and `pc_plus4_id` = 0x44.
- `branch_taken` = 1 together with `stall` = 1 -> `pc` holds and the redirect is ignored. `jump` = 1 together with `branch_taken` = 1 -> `pc` = `branch_target`.
- With `FETCH_STALL_CNT_EN`: 3 stall cycles -> `stall_count` = 3. Preloading the counter to 32'hFFFF_FFFE and applying 3 stall cycles -> `stall_count` = 32'hFFFF_FFFF. `rst` pulse -> `stall_count` = 0.
